slc3_mem_arbiter: RTL

Memory access sequencer and arbiter for the SLC-3. It sits between the CPU's MAR/MDR memory port, a debug/program-loader port, and the synchronous on-chip SRAM. It shares the single SRAM port between the two requesters and inserts the SRAM wait states. It also decodes the memory-mapped I/O word: switch reads and hex-display writes.

---
 rtl/slc3_mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/slc3_mem_arbiter.sv
// SLC-3 memory sequencer: arbitrates the CPU and loader ports onto one synchronous
// SRAM port, inserts the SRAM wait states and decodes the switch/hex I/O word.
module slc3_mem_arbiter #(
  parameter int          ADDR_W  = 10,
  parameter int          MEM_LAT = 2,
  parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [15:0]       dbg_addr,
  input  logic [15:0]       dbg_wdata,
  output logic [15:0]       dbg_rdata,
  output logic              dbg_ready,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic [15:0]       SW,
  output logic [15:0]       hex_display,
  output logic              busy
);

  // state  | meaning
  // IDLE   | sample requests, grant, decode address
  // ACCESS | SRAM cycle in progress, MEM_LAT cycles long
  // DONE   | owner's ready pulse, back to IDLE next edge
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int                CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [16:0]       MEM_SIZE = 17'(1) << ADDR_W;

  state_t           state;
  logic             owner_dbg;
  logic             last_dbg;
  logic             we_q;
  logic [CNT_W-1:0] cnt;

  logic             grant_dbg;
  logic             sel_we;
  logic [15:0]      sel_addr;
  logic [15:0]      sel_wdata;
  logic             sel_io;
  logic             sel_mem;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant_dbg = dbg_req;
    if (cpu_req && dbg_req) grant_dbg = ~last_dbg;
    sel_we    = grant_dbg ? dbg_we    : cpu_we;
    sel_addr  = grant_dbg ? dbg_addr  : cpu_addr;
    sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;
    sel_io    = (sel_addr == IO_ADDR);
    sel_mem   = ({1'b0, sel_addr} < MEM_SIZE);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      owner_dbg   <= 1'b0;
      last_dbg    <= 1'b0;
      we_q        <= 1'b0;
      cnt         <= '0;
      cpu_ready   <= 1'b0;
      dbg_ready   <= 1'b0;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
      mem_ce      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      hex_display <= '0;
    end else begin
      cpu_ready <= 1'b0;
      dbg_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            owner_dbg <= grant_dbg;
            last_dbg  <= grant_dbg;
            we_q      <= sel_we;
            if (sel_io) begin
              if (sel_we)         hex_display <= sel_wdata;
              else if (grant_dbg) dbg_rdata   <= SW;
              else                cpu_rdata   <= SW;
              cpu_ready <= ~grant_dbg;
              dbg_ready <= grant_dbg;
              state     <= DONE;
            end else if (sel_mem) begin
              mem_ce    <= 1'b1;
              mem_we    <= sel_we;
              mem_addr  <= sel_addr[ADDR_W-1:0];
              mem_wdata <= sel_wdata;
              cnt       <= CNT_LOAD;
              state     <= ACCESS;
            end else begin
              // Unmapped address: reads return zero, writes vanish.
              if (!sel_we) begin
                if (grant_dbg) dbg_rdata <= '0;
                else           cpu_rdata <= '0;
              end
              cpu_ready <= ~grant_dbg;
              dbg_ready <= grant_dbg;
              state     <= DONE;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            mem_ce <= 1'b0;
            mem_we <= 1'b0;
            if (!we_q) begin
              if (owner_dbg) dbg_rdata <= mem_rdata;
              else           cpu_rdata <= mem_rdata;
            end
            cpu_ready <= ~owner_dbg;
            dbg_ready <= owner_dbg;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
